// File: rtl/fpu_pkg.sv
// Shared FP32 add-pipeline definitions: widths, IEEE flag bit positions, canonical qNaN, pipe latency.
package fpu_pkg;

  localparam int FP_W   = 32;
  localparam int FLAG_W = 5;

  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIV_ZERO  = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam logic [FP_W-1:0] FP32_QNAN = 32'h7FC0_0000;

  localparam int FPU_ADD_LATENCY = 3;

  typedef logic [FP_W-1:0]   fp32_t;
  typedef logic [FLAG_W-1:0] fpu_flags_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Show-ahead FIFO with registered head outputs; push-to-head latency 1 cycle.
// Push and pop may coincide in any state; a push into a full FIFO is dropped unless a pop frees the slot.
module fpu_rsp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_head_vld,
  output logic [WIDTH-1:0] o_head_dat,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_head_vld;
  logic [WIDTH-1:0] r_head_dat;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0] w_cnt_left;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_pop      = i_pop && r_head_vld;
    w_push     = i_push_vld && ((r_count != CNT_W'(DEPTH)) || w_pop);
    w_rd_nxt   = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_cnt_left = r_count - CNT_W'(w_pop);
    w_cnt_nxt  = w_cnt_left + CNT_W'(w_push);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_head_vld <= 1'b0;
      r_head_dat <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr   <= w_rd_nxt;
      r_count    <= w_cnt_nxt;
      r_head_vld <= (w_cnt_nxt != '0);
      // With nothing left after the pop the incoming entry bypasses memory straight to the head.
      if (w_cnt_left == '0) begin
        if (w_push) begin
          r_head_dat <= i_push_dat;
        end
      end else begin
        r_head_dat <= r_mem[w_rd_nxt];
      end
    end
  end

  assign o_head_vld = r_head_vld;
  assign o_head_dat = r_head_dat;
  assign o_count    = r_count;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues tagged FP32 add requests to a fixed-latency FPU and collects results into a credit-protected FIFO.
// Accept-to-response latency LATENCY+2 cycles; req_ready drops once in-flight plus buffered ops reach DEPTH.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LATENCY = FPU_ADD_LATENCY,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FP_W-1:0]   req_a,
  input  logic [FP_W-1:0]   req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              fpu_start,
  output logic [FP_W-1:0]   fpu_a,
  output logic [FP_W-1:0]   fpu_b,
  input  logic              fpu_valid,
  input  logic [FP_W-1:0]   fpu_result,
  input  logic [FLAG_W-1:0] fpu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [FP_W-1:0]   rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              clear_flags,
  output logic [FLAG_W-1:0] acc_flags,
  output logic              protocol_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_CREDIT = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [FP_W-1:0]   result;
    logic [FLAG_W-1:0] flags;
    logic [TAG_W-1:0]  tag;
  } rsp_ent_t;

  logic                r_start;
  logic [FP_W-1:0]     r_a;
  logic [FP_W-1:0]     r_b;
  logic [TAG_W-1:0]    r_tag;
  logic [LATENCY-1:0]  r_slot_vld;
  logic [TAG_W-1:0]    r_slot_tag [LATENCY];
  logic [CNT_W-1:0]    r_inflight;
  logic [FLAG_W-1:0]   r_acc;
  logic                r_err;

  logic                w_accept;
  logic                w_expected;
  logic                w_capture;
  logic [CNT_W-1:0]    w_count;
  rsp_ent_t            w_push_ent;
  rsp_ent_t            w_head_ent;

  // Credit is derived from registers only, so a pop frees a slot starting the following cycle.
  assign req_ready  = ({1'b0, r_inflight} + {1'b0, w_count}) < DEPTH_CREDIT;
  assign w_accept   = req_valid && req_ready;
  assign w_expected = r_slot_vld[LATENCY-1];
  assign w_capture  = fpu_valid && w_expected;
  assign w_push_ent = '{result: fpu_result, flags: fpu_flags, tag: r_slot_tag[LATENCY-1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_tag      <= '0;
      r_slot_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_slot_tag[i] <= '0;
      end
      r_inflight <= '0;
      r_acc      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_a   <= req_a;
        r_b   <= req_b;
        r_tag <= req_tag;
      end
      // Slot k holds the op started k+1 cycles ago; the last slot lines up with the FPU strobe.
      r_slot_vld[0] <= r_start;
      r_slot_tag[0] <= r_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_slot_vld[i] <= r_slot_vld[i-1];
        r_slot_tag[i] <= r_slot_tag[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_expected);
      r_acc      <= (clear_flags ? '0 : r_acc) | (w_capture ? fpu_flags : '0);
      if (fpu_valid != w_expected) begin
        r_err <= 1'b1;
      end
    end
  end

  fpu_rsp_fifo #(
    .WIDTH ($bits(rsp_ent_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (w_capture),
    .i_push_dat (w_push_ent),
    .i_pop      (rsp_ready),
    .o_head_vld (rsp_valid),
    .o_head_dat (w_head_ent),
    .o_count    (w_count)
  );

  assign fpu_start    = r_start;
  assign fpu_a        = r_a;
  assign fpu_b        = r_b;
  assign rsp_result   = w_head_ent.result;
  assign rsp_flags    = w_head_ent.flags;
  assign rsp_tag      = w_head_ent.tag;
  assign acc_flags    = r_acc;
  assign protocol_err = r_err;
  assign busy         = (r_inflight != '0) || (w_count != '0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized bench for fpu_issue_ctrl with an environment FPU model and a transaction-level reference.
module tb_fpu_issue_ctrl;
  localparam int LAT = 3;
  localparam int DEP = 4;
  localparam int TW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_a = '0;
  logic [31:0]   req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic          fpu_start;
  logic [31:0]   fpu_a;
  logic [31:0]   fpu_b;
  logic          fpu_valid = 1'b0;
  logic [31:0]   fpu_result = '0;
  logic [4:0]    fpu_flags = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic [4:0]    rsp_flags;
  logic [TW-1:0] rsp_tag;
  logic          clear_flags = 1'b0;
  logic [4:0]    acc_flags;
  logic          protocol_err;
  logic          busy;

  fpu_issue_ctrl #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_valid(fpu_valid), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag), .clear_flags(clear_flags), .acc_flags(acc_flags),
    .protocol_err(protocol_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int vis; logic [31:0] res; logic [4:0] flg; logic [TW-1:0] tag; } ent_t;
  typedef struct { logic [4:0] flg; bit delay; } op_t;
  typedef struct { int cyc; logic [31:0] res; logic [4:0] flg; } ret_t;

  ent_t pend[$];
  ent_t vis_q[$];
  op_t  iss_q[$];
  ret_t ret_q[$];
  int   drop_rel[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          dut_acc = 0;
  int          last_acc_cyc = 0;
  bit          last_acc = 0;
  bit          prev_acc = 0;
  logic [31:0] prev_a = '0, prev_b = '0;
  logic        m_err = 0;
  logic [4:0]  m_acc = '0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_flg = '0;
  logic [TW-1:0] last_tag = '0;
  logic [4:0]  cur_flg = '0;
  bit          cur_delay = 0;

  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a + b) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tag, input logic [4:0] flg);
    req_valid = v; req_a = a; req_b = b; req_tag = tag; cur_flg = flg;
  endtask

  // One clock cycle: drive the FPU side, check at negedge, advance the reference, step past posedge.
  task automatic tick();
    bit m_ready, acc, pop;
    logic [4:0] nxt_acc;
    if (ret_q.size() != 0 && ret_q[0].cyc == cyc) begin
      fpu_valid = 1'b1; fpu_result = ret_q[0].res; fpu_flags = ret_q[0].flg;
      void'(ret_q.pop_front());
    end else begin
      fpu_valid = 1'b0; fpu_result = $urandom; fpu_flags = 5'($urandom);
    end
    @(negedge clk);
    while (pend.size() != 0 && pend[0].vis <= cyc) vis_q.push_back(pend.pop_front());
    m_ready = (n_out < DEP);
    chk("req_ready", req_ready, m_ready);
    chk("busy", busy, n_out != 0);
    chk("fpu_start", fpu_start, prev_acc);
    if (prev_acc) begin
      chk("fpu_a", fpu_a, prev_a);
      chk("fpu_b", fpu_b, prev_b);
    end
    chk("protocol_err", protocol_err, m_err);
    chk("acc_flags", acc_flags, m_acc);
    chk("rsp_valid", rsp_valid, vis_q.size() != 0);
    if (vis_q.size() != 0) begin
      last_res = vis_q[0].res; last_flg = vis_q[0].flg; last_tag = vis_q[0].tag;
    end
    chk("rsp_result", rsp_result, last_res);
    chk("rsp_flags", rsp_flags, last_flg);
    chk("rsp_tag", rsp_tag, last_tag);
    if (req_valid && req_ready) dut_acc++;
    if (fpu_start && iss_q.size() != 0) begin
      op_t op = iss_q.pop_front();
      ret_q.push_back('{cyc + LAT + (op.delay ? 1 : 0), fadd_model(fpu_a, fpu_b), op.flg});
    end
    acc = req_valid && m_ready && rst;
    pop = rsp_ready && (vis_q.size() != 0) && rst;
    last_acc = acc;
    if (!rst) begin
      pend.delete(); vis_q.delete(); iss_q.delete(); ret_q.delete(); drop_rel.delete();
      n_out = 0; prev_acc = 0; m_err = 0; m_acc = '0;
      last_res = '0; last_flg = '0; last_tag = '0;
    end else begin
      nxt_acc = clear_flags ? 5'd0 : m_acc;
      if (pend.size() != 0 && pend[0].vis == cyc + 1) nxt_acc |= pend[0].flg;
      m_acc = nxt_acc;
      if (drop_rel.size() != 0 && drop_rel[0] == cyc) begin
        void'(drop_rel.pop_front());
        n_out--;
        m_err = 1;
      end
      if (pop) begin
        void'(vis_q.pop_front());
        n_out--;
      end
      if (acc) begin
        n_out++;
        last_acc_cyc = cyc;
        iss_q.push_back('{cur_flg, cur_delay});
        if (cur_delay) drop_rel.push_back(cyc + LAT + 1);
        else pend.push_back('{cyc + LAT + 2, fadd_model(req_a, req_b), cur_flg, req_tag});
      end
      prev_acc = acc; prev_a = req_a; prev_b = req_b;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (n_out != 0 || vis_q.size() != 0); i++) tick();
    chk(tag, (n_out == 0 && vis_q.size() == 0), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", fpu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc_flags, 0);
    chk("rst_err", protocol_err, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_fpu_a", fpu_a, 0);
    rst = 1'b1;

    // single op
    rsp_ready = 1'b1;
    drive(1, 32'h3F80_0000, 32'h4000_0000, 4'd5, 5'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    drain("single_drain");
    chk("single_hold", rsp_result, 32'h4040_0000);
    chk("single_tag", rsp_tag, 4'd5);
    chk("single_busy", busy, 0);

    // backpressure: six offered, four fit
    rsp_ready = 1'b0;
    dut_acc = 0;
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h1000 + sent, 32'h2000, TW'(sent), 5'd0);
      tick();
      if (last_acc) sent++;
    end
    chk("bp_accepted", dut_acc, 4);
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && sent < 6; i++) begin
      drive(1, 32'h1000 + sent, 32'h2000, TW'(sent), 5'd0);
      tick();
      if (last_acc) sent++;
    end
    drive(0, 0, 0, 0, 0);
    drain("bp_drain");
    chk("bp_last_tag", rsp_tag, 4'd5);

    // sticky flags and same-cycle clear
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    drive(1, 32'h11, 32'h22, 4'd1, 5'h01);
    tick();
    drive(1, 32'h7FC0_0000, 32'h33, 4'd2, 5'h10);
    tick();
    drive(0, 0, 0, 0, 0);
    drain("flg_drain");
    chk("flags_or", acc_flags, 5'h11);
    drive(1, 32'h7F00_0000, 32'h7F00_0000, 4'd3, 5'h04);
    tick();
    drive(0, 0, 0, 0, 0);
    while (cyc < last_acc_cyc + LAT + 1) tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    tick();
    chk("flags_clr", acc_flags, 5'h04);
    drain("flg3_drain");

    // late FPU strobe
    cur_delay = 1;
    drive(1, 32'hABC, 32'hDEF, 4'd7, 5'd0);
    tick();
    cur_delay = 0;
    drive(0, 0, 0, 0, 0);
    repeat (8) tick();
    chk("proto_err", protocol_err, 1);
    chk("proto_busy", busy, 0);
    drive(1, 32'h3F80_0000, 32'h4000_0000, 4'd9, 5'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    drain("proto_drain");
    chk("proto_after", rsp_tag, 4'd9);

    // reset with three in flight and one buffered
    rsp_ready = 1'b0;
    drive(1, 32'h1, 32'h2, 4'd10, 5'h02);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + i, 32'h200, TW'(11 + i), 5'h08);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", req_ready, 1);
    chk("mrst_start", fpu_start, 0);
    chk("mrst_err", protocol_err, 0);
    chk("mrst_acc", acc_flags, 0);
    chk("mrst_result", rsp_result, 0);
    chk("mrst_tag", rsp_tag, 0);
    rsp_ready = 1'b1;
    repeat (10) tick();

    // random traffic, continuous at first
    for (int i = 0; i < 400; i++) begin
      drive((i < 60) || ($urandom_range(0, 7) != 0), $urandom, $urandom, TW'($urandom),
            5'($urandom_range(0, 31)));
      rsp_ready = (i < 60) || ($urandom_range(0, 3) != 0);
      clear_flags = ($urandom_range(0, 7) == 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    clear_flags = 1'b0;
    rsp_ready = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
